// File: rtl/pipelined_add_sub_unit.sv
// Pipelined ripple-slice adder/subtractor: each stage adds WIDTH/STAGES bits and forwards its carry.
// Define ADDER_RESULT_FLAGS_EN to add registered out_zero/out_neg result flags.
module pipelined_add_sub_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
`ifdef ADDER_RESULT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);
  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  // Entry k holds the operation after slice k has been added.
  logic             vld_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] sum_p [STAGES];
  logic             cy_p  [STAGES];
  logic [TAG_W-1:0] tag_p [STAGES];
  logic             ovf_p;

  logic             vld_src [STAGES];
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] sum_src [STAGES];
  logic             cy_src  [STAGES];
  logic [TAG_W-1:0] tag_src [STAGES];
  logic [WIDTH-1:0] sum_nx  [STAGES];
  logic             cy_nx   [STAGES];
  logic [S:0]       slice_t;
  logic             ovf_nx;
  logic             adv;

`ifdef ADDER_RESULT_FLAGS_EN
  logic zero_p, neg_p;
  logic zero_nx, neg_nx;
`endif

  function automatic logic [S:0] slice_add(input logic [S-1:0] a, input logic [S-1:0] b,
                                           input logic c);
    return {1'b0, a} + {1'b0, b} + {{S{1'b0}}, c};
  endfunction

  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign adv       = !vld_p[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p[L];
  assign out_sum   = sum_p[L];
  assign out_cout  = cy_p[L];
  assign out_ovf   = ovf_p;
  assign out_tag   = tag_p[L];
`ifdef ADDER_RESULT_FLAGS_EN
  assign out_zero  = zero_p;
  assign out_neg   = neg_p;
`endif

  always_comb begin
    slice_t    = '0;
    // Subtraction feeds ~B with a forced carry-in of 1; in_cin is ignored then.
    vld_src[0] = in_valid && adv;
    a_src[0]   = in_a;
    b_src[0]   = in_sub ? ~in_b : in_b;
    sum_src[0] = '0;
    cy_src[0]  = in_sub | in_cin;
    tag_src[0] = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      vld_src[k] = vld_p[k-1];
      a_src[k]   = a_p[k-1];
      b_src[k]   = b_p[k-1];
      sum_src[k] = sum_p[k-1];
      cy_src[k]  = cy_p[k-1];
      tag_src[k] = tag_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_t              = slice_add(a_src[k][k*S +: S], b_src[k][k*S +: S], cy_src[k]);
      sum_nx[k]            = sum_src[k];
      sum_nx[k][k*S +: S]  = slice_t[S-1:0];
      cy_nx[k]             = slice_t[S];
    end
    ovf_nx = ovf_flag(a_src[L][WIDTH-1], b_src[L][WIDTH-1], sum_nx[L][WIDTH-1]);
`ifdef ADDER_RESULT_FLAGS_EN
    zero_nx = (sum_nx[L] == '0);
    neg_nx  = sum_nx[L][WIDTH-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        sum_p[k] <= '0;
        cy_p[k]  <= 1'b0;
        tag_p[k] <= '0;
      end
      ovf_p <= 1'b0;
`ifdef ADDER_RESULT_FLAGS_EN
      zero_p <= 1'b0;
      neg_p  <= 1'b0;
`endif
    end else if (flush) begin
      // Squash only the valid bits; stale data is harmless once invalid.
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= vld_src[k];
        a_p[k]   <= a_src[k];
        b_p[k]   <= b_src[k];
        sum_p[k] <= sum_nx[k];
        cy_p[k]  <= cy_nx[k];
        tag_p[k] <= tag_src[k];
      end
      ovf_p <= ovf_nx;
`ifdef ADDER_RESULT_FLAGS_EN
      zero_p <= zero_nx;
      neg_p  <= neg_nx;
`endif
    end
  end
endmodule
